// File: rtl/mips_cache_controller.sv
// Write-through buffer and miss-fill controller that sits beside a MIPS data cache.
// CPU writes are posted to a small FIFO and drained to an Avalon-style memory
// master; a cache miss triggers a single-word fill once all posted writes are out.
module mips_cache_controller #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byte_en,
  input  logic        stall,
  output logic [31:0] data_in,
  output logic        data_valid,
  output logic        ctrl_stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [29:0]        wb_addr_q [WBUF_DEPTH];
  logic [31:0]        wb_data_q [WBUF_DEPTH];
  logic [3:0]         wb_be_q   [WBUF_DEPTH];

  logic [31:0]        data_in_q;
  logic               data_valid_q;
  logic [31:0]        mem_address_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [31:0]        mem_writedata_q;
  logic [3:0]         mem_byteenable_q;

  logic               wbuf_full;
  logic               wbuf_empty;
  logic               push;
  logic               pop;
  logic               miss;
  logic               addr_lo_unused;

  // Byte offset bits never reach memory: the bus is word addressed with byte enables.
  assign addr_lo_unused = ^addr[1:0];

  assign wbuf_full  = (count_q == CNT_W'(WBUF_DEPTH));
  assign wbuf_empty = (count_q == '0);
  assign ctrl_stall = write_en & ~stall & wbuf_full;
  assign push       = write_en & ~stall & ~wbuf_full;
  assign pop        = (state_q == WRITE) & ~mem_waitrequest;
  assign miss       = stall & (read_en | write_en);

  assign data_in        = data_in_q;
  assign data_valid     = data_valid_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;

  // Next pointer/count values; pointers wrap naturally because depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Write-buffer occupancy bookkeeping; reset discards every posted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write-buffer payload storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= addr[31:2];
      wb_data_q[wr_ptr_q] <= writedata;
      wb_be_q[wr_ptr_q]   <= byte_en;
    end
  end

  // Memory-side sequencer: posted writes always win over a fill, keeping RAW order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      data_in_q        <= '0;
      data_valid_q     <= 1'b0;
      mem_address_q    <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!wbuf_empty) begin
            state_q          <= WRITE;
            mem_write_q      <= 1'b1;
            mem_address_q    <= {wb_addr_q[rd_ptr_q], 2'b00};
            mem_writedata_q  <= wb_data_q[rd_ptr_q];
            mem_byteenable_q <= wb_be_q[rd_ptr_q];
          end else if (miss) begin
            state_q          <= FILL;
            mem_read_q       <= 1'b1;
            mem_address_q    <= {addr[31:2], 2'b00};
            mem_byteenable_q <= 4'b1111;
          end
        end
        WRITE: begin
          if (!mem_waitrequest) begin
            state_q     <= IDLE;
            mem_write_q <= 1'b0;
          end
        end
        FILL: begin
          if (!mem_waitrequest) begin
            state_q      <= DONE;
            mem_read_q   <= 1'b0;
            data_in_q    <= mem_readdata;
            data_valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          data_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          data_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_cache_controller.md
MIPS_CACHE_CONTROLLER -- requirements
Module: mips_cache_controller

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports addr  input  32, read_en  input  1, write_en  input  1, writedata  input  32, byte_en  input  4: CPU request, snooped in parallel with the data cache.
REQ-005 SHALL have port stall  input  1  miss indication from the data cache.
REQ-006 SHALL have ports data_in  output  32 and data_valid  output  1: fill word and its one-cycle strobe to the data cache.
REQ-007 SHALL have port ctrl_stall  output  1  CPU hold request when the write buffer is full.
REQ-008 SHALL have ports mem_address  output  32, mem_read  output  1, mem_write  output  1, mem_writedata  output  32, mem_byteenable  output  4, mem_readdata  input  32, mem_waitrequest  input  1: Avalon-style memory master.

Function
REQ-009 SHALL implement a write-through policy: every accepted CPU write is posted to a WBUF_DEPTH-entry FIFO holding {word address, writedata, byte_en}.
REQ-010 SHALL accept a push in a cycle where write_en=1, stall=0 and ctrl_stall=0; exactly one push per such cycle.
REQ-011 SHALL drive ctrl_stall combinationally = write_en & !stall & wbuf_full; wbuf_full when count==WBUF_DEPTH.
REQ-012 SHALL store word address as {addr[31:2],2'b00}.
REQ-013 SHALL wrap read/write pointers modulo WBUF_DEPTH; simultaneous push and pop SHALL leave count unchanged; push while full SHALL NOT occur (ctrl_stall blocks it).
REQ-014 SHALL use an FSM with states IDLE, WRITE, FILL, DONE.
REQ-015 IDLE: if stall & (read_en|write_en) and FIFO non-empty -> WRITE; if stall & (read_en|write_en) and FIFO empty -> FILL, latching {addr[31:2],2'b00}; else if FIFO non-empty -> WRITE; else stay.
REQ-016 WRITE: mem_write=1, mem_address/mem_writedata/mem_byteenable = FIFO head; when mem_waitrequest=0 pop head and -> IDLE.
REQ-017 FILL: mem_read=1, mem_address=latched fill address, mem_byteenable=4'b1111; when mem_waitrequest=0 register mem_readdata into data_in and -> DONE.
REQ-018 DONE: data_valid=1 for exactly one cycle, -> IDLE; data_in SHALL hold its value until the next fill completes.
REQ-019 Pending posted writes SHALL always drain before any fill is issued (read-after-write ordering to memory).
REQ-020 mem_read and mem_write SHALL never be asserted in the same cycle; mem_* outputs SHALL stay stable while mem_waitrequest=1.
REQ-021 Changes on addr during FILL/DONE SHALL NOT affect the in-flight fill address.
REQ-022 A new fill SHALL NOT start in the cycle after DONE unless stall is still asserted then.
REQ-023 Outside WRITE, mem_write=0; outside FILL, mem_read=0; data_valid=0 in all states except DONE.

Reset
REQ-024 rst=0 SHALL immediately force: state IDLE, FIFO count and pointers 0, data_valid 0, data_in 0, mem_read 0, mem_write 0, mem_address 0, mem_byteenable 0, ctrl_stall 0.
REQ-025 Reset mid-transaction SHALL abandon the memory access and discard buffered writes; no data_valid pulse follows.
REQ-026 Operation SHALL resume on the first rising clk edge after rst returns to 1.

Verification
REQ-027 Read miss: FIFO empty, stall=1, read_en=1, addr=0x00000104, waitrequest=1 for 2 cycles then 0 with readdata=0xDEADBEEF -> mem_read with mem_address 0x00000104, byteenable 1111; next cycle data_valid=1 one cycle, data_in=0xDEADBEEF.
REQ-028 Write-through: three hit writes to 0x10,0x14,0x18 data 1,2,3, waitrequest=0 -> three mem_write cycles in that order with matching data, byteenable 1111.
REQ-029 Full buffer: WBUF_DEPTH=4, waitrequest=1, five consecutive hit writes -> ctrl_stall=1 on fifth; release waitrequest -> five writes drain in order, ctrl_stall clears after first pop.
REQ-030 Ordering: one posted write to 0x20 pending, then read miss at 0x20 -> mem_write to 0x20 completes before mem_read to 0x20 asserts.
REQ-031 Partial write: write hit addr=0x00000107, byte_en=0011 -> mem_address 0x00000104, mem_byteenable 0011.
REQ-032 Reset mid-fill: rst=0 while mem_read=1 -> mem_read=0 same cycle, no data_valid, FIFO empty after release.
